// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus arbiter: one-hot FSM state encoding,
// the idle levels of the 8080-style write bus, and the LCD command codes
// used by the requester blocks (column set, page set, memory write).
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_GRANT = 3'b010,
    S_GAP   = 3'b100
  } arb_state_t;

  // Bus levels while nobody owns the LCD: chip deselected, no write strobe.
  localparam logic [15:0] LCD_IDLE_DATA = 16'h0000;
  localparam logic        LCD_IDLE_RS   = 1'b0;
  localparam logic        LCD_IDLE_CS   = 1'b1;
  localparam logic        LCD_IDLE_WR   = 1'b1;

  localparam logic [15:0] LCD_CMD_CASET = 16'h002A;
  localparam logic [15:0] LCD_CMD_PASET = 16'h002B;
  localparam logic [15:0] LCD_CMD_RAMWR = 16'h002C;

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side and LCD-pin-side signals of the LCD bus arbiter.
//   master : requester blocks / pins (drive req, done, req_* ; see grant, LCD_*)
//   slave  : the arbiter itself
// req_data packs requester i at [16i+15:16i].
interface lcd_bus_arbiter_if #(parameter int NREQ = 3);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      grant;
  logic [16*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_rs;
  logic [NREQ-1:0]      req_cs;
  logic [NREQ-1:0]      req_wr;
  logic [15:0]          LCD_DATA;
  logic                 LCD_RS;
  logic                 LCD_CS;
  logic                 LCD_WR;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req, done, req_data, req_rs, req_cs, req_wr,
    input  grant, LCD_DATA, LCD_RS, LCD_CS, LCD_WR, busy, timeout_err
  );

  modport slave (
    input  req, done, req_data, req_rs, req_cs, req_wr,
    output grant, LCD_DATA, LCD_RS, LCD_CS, LCD_WR, busy, timeout_err
  );
endinterface

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin selector.
//   req   : pending requests
//   ptr   : index of the last requester served (lowest priority)
//   pick  : one-hot winner, searching upward from ptr+1 with wrap-around
//   valid : any request pending
module lcd_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one 16-bit 8080-style LCD write bus between NREQ requesters.
// Round-robin grant, held until the owner pulses done or drops req, then
// IDLE_GAP cycles of deselected bus before the next arbitration.
// While granted, the owner's data/rs/cs/wr are registered onto the pins.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lcd_bus_arbiter_if.slave (requests, grants, LCD pins, status)
// Optional: define LCD_ARB_TIMEOUT_EN to enable the grant watchdog
// (TIMEOUT_CYCLES); otherwise timeout_err is constant 0.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int IDLE_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  lcd_bus_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  arb_state_t      state;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] pick;
  logic            pick_vld;
  logic [PW-1:0]   ptr;        // last granted index; equals owner while in GRANT
  logic [PW-1:0]   pick_idx;
  logic [GW-1:0]   gap_cnt;
  logic [15:0]     lcd_data;
  logic            lcd_rs, lcd_cs, lcd_wr;
  logic            busy_q, terr_q;
  logic            release_req;
  logic            wd_hit;

  lcd_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  // Only the owner's done/req matter; everyone else is masked by grant_q.
  assign release_req = (|(bus.done & grant_q)) || !(|(bus.req & grant_q));

`ifdef LCD_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Held at zero outside GRANT so every grant starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wd_cnt <= '0;
    else if (state != S_GRANT) wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + 16'd1;
  end

  assign wd_hit = (state == S_GRANT) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog limit has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      grant_q  <= '0;
      ptr      <= PW'(NREQ - 1);
      gap_cnt  <= '0;
      lcd_data <= LCD_IDLE_DATA;
      lcd_rs   <= LCD_IDLE_RS;
      lcd_cs   <= LCD_IDLE_CS;
      lcd_wr   <= LCD_IDLE_WR;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      terr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          lcd_data <= LCD_IDLE_DATA;
          lcd_rs   <= LCD_IDLE_RS;
          lcd_cs   <= LCD_IDLE_CS;
          lcd_wr   <= LCD_IDLE_WR;
          if (pick_vld) begin
            grant_q <= pick;
            ptr     <= pick_idx;
            busy_q  <= 1'b1;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (release_req || wd_hit) begin
            // Done/abort win over the watchdog, so err only flags a true hang.
            grant_q  <= '0;
            lcd_data <= LCD_IDLE_DATA;
            lcd_rs   <= LCD_IDLE_RS;
            lcd_cs   <= LCD_IDLE_CS;
            lcd_wr   <= LCD_IDLE_WR;
            gap_cnt  <= '0;
            terr_q   <= !release_req;
            state    <= S_GAP;
          end else begin
            lcd_data <= bus.req_data[int'(ptr)*16 +: 16];
            lcd_rs   <= bus.req_rs[ptr];
            lcd_cs   <= bus.req_cs[ptr];
            lcd_wr   <= bus.req_wr[ptr];
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(IDLE_GAP - 1)) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.LCD_DATA    = lcd_data;
  assign bus.LCD_RS      = lcd_rs;
  assign bus.LCD_CS      = lcd_cs;
  assign bus.LCD_WR      = lcd_wr;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule
